ip_feeder: RTL and testbench

- Upstream stage of the 8x8 image-filter IP; sole driver of its in_valid_1/in_image/in_valid_2/in_mode inputs.
- Accepts pixels and mode commands from a host over two valid/ready channels.
- Buffers a full frame so the IP sees 64 back-to-back pixel cycles, then the mode cycle.
- Blocks further launches until the IP has returned all results.

---
 rtl/ip_pkg.sv | 16 +
 rtl/ip_feed_buf.sv | 19 +
 rtl/ip_feeder.sv | 101 ++++++++++
 tb/tb_ip_feeder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_pkg.sv
// ip_pkg: shared types and constants for the image-filter feeder
// Contents: FSM state enum, filter mode codes, frame/result defaults, datapath widths.
package ip_pkg;
    localparam int NPIX_DEF = 64;
    localparam int NRES_DEF = 64;
    localparam int PIX_W    = 8;
    localparam int MODE_W   = 2;
    localparam int PTR_W    = 6;
    localparam int CNT_W    = 7;

    localparam logic [MODE_W-1:0] MODE_SHARPEN = 2'd0;
    localparam logic [MODE_W-1:0] MODE_MEAN    = 2'd1;
    localparam logic [MODE_W-1:0] MODE_MID     = 2'd2;

    typedef enum logic [2:0] {IDLE, FILL, ARM, SEND_IMG, SEND_MODE, WAIT} state_t;
endpackage

// File: rtl/ip_feed_buf.sv
// ip_feed_buf: 64x8 frame buffer, synchronous write, combinational read
// Ports: clk; we/wp/wd write port; rp -> rd read port.
module ip_feed_buf
    import ip_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] wp,
    input  logic [PIX_W-1:0] wd,
    input  logic [PTR_W-1:0] rp,
    output logic [PIX_W-1:0] rd
);
    logic [PIX_W-1:0] mem [2**PTR_W];

    always_ff @(posedge clk)
        if (we) mem[wp] <= wd;

    assign rd = mem[rp];
endmodule

// File: rtl/ip_feeder.sv
// ip_feeder: buffers a host frame and drives it plus a mode strobe into the image-filter IP
// Ports: clk, rst (sync, active high); host img_* and mode_* valid/ready channels;
//        IP side in_valid_1/in_image/in_valid_2/in_mode; out_valid observed from the IP;
//        busy, done (result count reached), err (watchdog pulse).
// Macro IP_FEED_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT cycles; otherwise err is 0.
module ip_feeder
    import ip_pkg::*;
#(
    parameter int NPIX = NPIX_DEF,
    parameter int NRES = NRES_DEF
`ifdef IP_FEED_TIMEOUT_EN
    , parameter int TIMEOUT = 1024
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              img_valid,
    output logic              img_ready,
    input  logic [PIX_W-1:0]  img_data,
    input  logic              mode_valid,
    output logic              mode_ready,
    input  logic [MODE_W-1:0] mode_data,
    output logic              in_valid_1,
    output logic [PIX_W-1:0]  in_image,
    output logic              in_valid_2,
    output logic [MODE_W-1:0] in_mode,
    input  logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_t state, nxt;
    logic [PTR_W-1:0]  wp, rp;
    logic [CNT_W-1:0]  rc;
    logic [MODE_W-1:0] md;
    logic [PIX_W-1:0]  pix;
    logic loaded, img_hs, mode_hs, fill_last, last_res, tmo;

    ip_feed_buf u_buf (.clk(clk), .we(img_hs), .wp(wp), .wd(img_data), .rp(rp), .rd(pix));

    assign img_hs    = img_valid & img_ready;
    assign mode_hs   = mode_valid & mode_ready;
    assign fill_last = state == FILL && img_hs && wp == PTR_W'(NPIX - 1);
    assign last_res  = state == WAIT && out_valid && rc == CNT_W'(NRES - 1);

`ifdef IP_FEED_TIMEOUT_EN
    logic [15:0] tc;
    assign tmo = state == WAIT && !last_res && tc == 16'(TIMEOUT - 1);
    always_ff @(posedge clk)
        if (rst || state != WAIT) tc <= '0;
        else tc <= tc + 16'd1;
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wp     <= '0;
            rp     <= '0;
            rc     <= '0;
            md     <= '0;
            loaded <= 1'b0;
        end else begin
            state <= nxt;
            if (img_hs) wp <= wp + PTR_W'(1);
            if (state == SEND_IMG) rp <= rp + PTR_W'(1);
            if (mode_hs) md <= mode_data;
            if (fill_last) loaded <= 1'b1;
            else if (tmo) loaded <= 1'b0;
            rc <= state == SEND_MODE ? '0 : (state == WAIT && out_valid) ? rc + CNT_W'(1) : rc;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = img_hs ? FILL : mode_hs ? SEND_MODE : IDLE;
            FILL:      nxt = fill_last ? ARM : FILL;
            ARM:       nxt = mode_hs ? SEND_IMG : ARM;
            SEND_IMG:  nxt = rp == PTR_W'(NPIX - 1) ? SEND_MODE : SEND_IMG;
            SEND_MODE: nxt = WAIT;
            WAIT:      nxt = (last_res || tmo) ? IDLE : WAIT;
            default:   nxt = IDLE;
        endcase
    end

    // Host readies and status pulses are forced low while rst is held; in IDLE a
    // pending pixel withholds mode_ready so image keeps priority without a lost command.
    always_comb begin
        img_ready  = !rst && (state == IDLE || state == FILL);
        mode_ready = !rst && (state == ARM || (state == IDLE && loaded && !img_valid));
        in_valid_1 = state == SEND_IMG;
        in_image   = in_valid_1 ? pix : '0;
        in_valid_2 = state == SEND_MODE;
        in_mode    = in_valid_2 ? md : '0;
        busy       = state == SEND_IMG || state == SEND_MODE || state == WAIT;
        done       = !rst && last_res;
        err        = !rst && tmo;
    end
endmodule

// File: tb/tb_ip_feeder.sv
// tb_ip_feeder: randomized scoreboard bench for ip_feeder
module tb_ip_feeder;
    import ip_pkg::*;

    localparam int NRES = 64;
`ifdef IP_FEED_TIMEOUT_EN
    localparam int TO = 100;
`endif

    logic clk = 0, rst = 1;
    logic img_valid = 0, mode_valid = 0, out_valid = 0;
    logic [7:0] img_data = 0;
    logic [1:0] mode_data = 0;
    logic img_ready, mode_ready, in_valid_1, in_valid_2, busy, done, err;
    logic [7:0] in_image;
    logic [1:0] in_mode;

    ip_feeder #(
        .NPIX(64), .NRES(NRES)
`ifdef IP_FEED_TIMEOUT_EN
        , .TIMEOUT(TO)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .img_valid(img_valid), .img_ready(img_ready), .img_data(img_data),
        .mode_valid(mode_valid), .mode_ready(mode_ready), .mode_data(mode_data),
        .in_valid_1(in_valid_1), .in_image(in_image),
        .in_valid_2(in_valid_2), .in_mode(in_mode),
        .out_valid(out_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {logic v1; logic v2; int d; int cyc;} ev_t;
    ev_t sb[$];
    ev_t mon_e;
    int cyc = 0;
    int errors = 0, checks = 0;
    int waiting = 0, nres = 0, wc = 0, ndone = 0, nerr = 0;
    logic now, ed, ee;
    logic [7:0] fr [64];
    bit armed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scheduled IP-side event for this cycle and tracks the result phase.
    always @(negedge clk) begin
        if (rst) waiting = 0;
        else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("strobe_missed", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            now = 0;
            if (sb.size() > 0) now = sb[0].cyc == cyc;
            ed = waiting != 0 && out_valid && nres == NRES - 1;
            ee = 0;
`ifdef IP_FEED_TIMEOUT_EN
            ee = waiting != 0 && !ed && wc == TO - 1;
`endif
            chk("busy", busy, now || waiting != 0);
            chk("done", done, ed);
            chk("err", err, ee);
            if (done && ed) ndone++;
            if (err && ee) nerr++;
            if (waiting != 0) begin
                nres += int'(out_valid);
                wc++;
                if (ed || ee) waiting = 0;
            end
            chk("strobe_exclusive", in_valid_1 && in_valid_2, 0);
            chk("image_zero_idle", in_valid_1 ? 0 : int'(in_image), 0);
            chk("mode_zero_idle", in_valid_2 ? 0 : int'(in_mode), 0);
            if (now) begin
                mon_e = sb.pop_front();
                chk("in_valid_1", in_valid_1, mon_e.v1);
                chk("in_valid_2", in_valid_2, mon_e.v2);
                chk("ip_data", in_valid_1 ? int'(in_image) : int'(in_mode), mon_e.d);
                if (mon_e.v2) begin
                    waiting = 1;
                    nres = 0;
                    wc = 0;
                end
            end else chk("unexpected_strobe", in_valid_1 || in_valid_2, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input bit rnd, input bit gaps, input bit hold_mode);
        bit ok;
        int k;
        for (int i = 0; i < 64; i++) begin
            fr[i] = rnd ? 8'($urandom) : 8'(i);
            img_valid = 1;
            img_data = fr[i];
            k = 0;
            do begin
                @(negedge clk);
                ok = img_ready;
                if (hold_mode) chk("mode_ready_in_fill", mode_ready, 0);
                tick();
                k++;
            end while (!ok && k < 50);
            if (!ok) chk("pixel_accept_timeout", 0, 1);
            if (gaps && i < 63) begin
                img_valid = 0;
                tick();
            end
        end
        img_valid = 0;
        armed = 1;
    endtask

    task automatic send_mode(input logic [1:0] m, input bit arm_chk, output int n);
        bit ok;
        int k = 0;
        mode_valid = 1;
        mode_data = m;
        do begin
            @(negedge clk);
            ok = mode_ready;
            if (k == 0 && arm_chk) begin
                chk("arm_mode_ready", mode_ready, 1);
                chk("arm_img_ready", img_ready, 0);
            end
            tick();
            k++;
        end while (!ok && k < 20);
        mode_valid = 0;
        n = cyc;
        if (!ok) chk("mode_accept_timeout", 0, 1);
        else begin
            if (armed) for (int i = 0; i < 64; i++) sb.push_back('{1'b1, 1'b0, int'(fr[i]), n + i});
            sb.push_back('{1'b0, 1'b1, int'(m), armed ? n + 64 : n});
            armed = 0;
        end
    endtask

    task automatic mode_stall(input logic [1:0] m);
        mode_valid = 1;
        mode_data = m;
        repeat (6) begin
            @(negedge clk);
            chk("mode_stalled", mode_ready, 0);
        end
        tick();
        mode_valid = 0;
        tick();
    endtask

    task automatic wait_result_phase();
        for (int k = 0; k < 200 && waiting == 0; k++) tick();
        chk("reach_wait", waiting, 1);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            out_valid = 1;
            tick();
            out_valid = 0;
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic finish_txn(input int n);
        int nd0 = ndone;
        pulses(n);
        tick();
        chk("txn_complete", waiting, 0);
        chk("done_count", ndone, nd0 + 1);
    endtask

    task automatic chk_reset_outputs();
        @(negedge clk);
        chk("rst_img_ready", img_ready, 0);
        chk("rst_mode_ready", mode_ready, 0);
        chk("rst_in_valid_1", in_valid_1, 0);
        chk("rst_in_image", in_image, 0);
        chk("rst_in_valid_2", in_valid_2, 0);
        chk("rst_in_mode", in_mode, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ne0;
        repeat (3) tick();
        chk_reset_outputs();
        tick();
        rst = 0;
        @(negedge clk);
        chk("idle_img_ready", img_ready, 1);
        chk("idle_mode_ready", mode_ready, 0);
        tick();

        // no frame loaded: mode command must stall
        mode_stall(MODE_MEAN);

        // ramp frame, no gaps, mode mean
        push_frame(0, 0, 0);
        send_mode(MODE_MEAN, 1, n);
        wait_result_phase();
        finish_txn(NRES);

        // stray results in IDLE are ignored, then mode-only reuse
        pulses(3);
        send_mode(MODE_SHARPEN, 0, n);
        wait_result_phase();
        finish_txn(NRES);

        // host gaps every other cycle, mode midpoint
        push_frame(1, 1, 0);
        send_mode(MODE_MID, 1, n);
        wait_result_phase();
        finish_txn(NRES);

        // both valids in IDLE: pixel wins, mode held through FILL
        mode_valid = 1;
        mode_data = MODE_MEAN;
        push_frame(1, 0, 1);
        send_mode(MODE_MEAN, 1, n);
        wait_result_phase();
        finish_txn(NRES);

        // reset during SEND_IMG after 20 pixels
        push_frame(1, 0, 0);
        send_mode(MODE_MID, 1, n);
        while (cyc < n + 20) tick();
        rst = 1;
        tick();
        chk_reset_outputs();
        sb.delete();
        tick();
        rst = 0;
        armed = 0;
        mode_stall(MODE_MID);

        // short result stream
        push_frame(1, 0, 0);
        send_mode(MODE_MEAN, 1, n);
        wait_result_phase();
        ne0 = nerr;
        pulses(10);
`ifdef IP_FEED_TIMEOUT_EN
        for (int k = 0; k < 200 && waiting != 0; k++) tick();
        chk("timeout_exit", waiting, 0);
        chk("err_count", nerr, ne0 + 1);
        mode_stall(MODE_MEAN);
`else
        repeat (150) tick();
        chk("still_waiting", waiting, 1);
        chk("no_err", nerr, ne0);
        finish_txn(NRES - 10);
`endif
        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
